// File: rtl/mem_master_pkg.sv
// mem_master shared types and constants.
// State encoding, word stride and default parameters.
package mem_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [31:0] STRIDE = 32'd4;

   localparam int BURST_MAX_DEF   = 4;
   localparam int WAIT_CYCLES_DEF = 1;

endpackage

// File: rtl/mem_master.sv
// Data memory initiator: sequences single/burst loads and stores
// beat by beat with per-beat handshakes back to the requester.
module mem_master
   import mem_master_pkg::*;
#(
   parameter int BURST_MAX   = BURST_MAX_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] reqAddr,
   input  logic [2:0]  burstLen,
   input  logic [31:0] wrData,
   output logic        wrAccept,
   output logic [31:0] rdData,
   output logic        rdValid,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] addr,
   output logic [31:0] data,
   input  logic [31:0] dataOut
);

   localparam logic [2:0] BMAX = 3'(BURST_MAX);
   localparam logic [2:0] WMAX = 3'(WAIT_CYCLES);

   state_t      state;
   state_t      nstate;
   logic [2:0]  beats;
   logic [2:0]  wcnt;
   logic [31:0] addr_q;
   logic        we_q;

   logic bad;
   logic accept;
   logic beat_end;
   logic last;

   assign bad = (reqAddr[1:0] != 2'b00)
             || (burstLen == 3'd0)
             || (burstLen > BMAX);

   assign accept   = (state == IDLE) && req && !bad;
   assign beat_end = (state == ACCESS) && (we_q || (wcnt == WMAX));
   assign last     = (beats == 3'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (req && !bad) nstate = SETUP;
         SETUP:   nstate = ACCESS;
         ACCESS:  if (beat_end) nstate = last ? DONE : SETUP;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      memRead  = (state == ACCESS) && !we_q;
      memWrite = (state == ACCESS) && we_q;
      wrAccept = memWrite;
      data     = memWrite ? wrData : 32'h0;
      busy     = (state != IDLE);
      done     = (state == DONE);
      addr     = addr_q;
   end

   // Read data is captured on the final wait edge so rdValid lands
   // in the following SETUP or DONE cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= 32'h0;
         beats   <= 3'd0;
         wcnt    <= 3'd0;
         we_q    <= 1'b0;
         err     <= 1'b0;
         rdData  <= 32'h0;
         rdValid <= 1'b0;
      end else begin
         err     <= (state == IDLE) && req && bad;
         rdValid <= 1'b0;
         if (accept) begin
            addr_q <= reqAddr;
            beats  <= burstLen;
            we_q   <= we;
         end
         if (state == SETUP) begin
            wcnt <= 3'd0;
         end
         if ((state == ACCESS) && !we_q) begin
            wcnt <= wcnt + 3'd1;
         end
         if (beat_end) begin
            beats <= beats - 3'd1;
            if (!last) begin
               addr_q <= addr_q + STRIDE;
            end
            if (!we_q) begin
               rdData  <= dataOut;
               rdValid <= 1'b1;
            end
         end
      end
   end

endmodule
